exe_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide engine in the EXE stage. It consumes the operands, rd and control that the ID/EXE pipeline register presents, and it is the consumer side of that register's hand-off. While an M-extension operation is in flight it drives a stall back so the ID/EXE register and the earlier stages hold. It returns one result with a one-cycle valid pulse that the EXE/MEM path uses as the register-write strobe.

---
 rtl/exe_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit
// Iterative RV32M multiply/divide engine for the EXE stage. Takes one
// M-extension op from the ID/EXE register, holds the front end with stall_o
// while it iterates one bit per cycle, and returns the result with a
// one-cycle valid_o pulse used as the register-write strobe.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         M-op present in ID/EXE (sampled only in IDLE)
//   op_i[2:0]       RV32M funct3
//   dataA_i/dataB_i rs1/rs2 operands (forwarded)
//   rd_i[4:0]       destination register
//   flush_i         kill of the in-flight op
//   result_o        result, meaningful while valid_o is high
//   rd_o            destination register of the returned result
//   valid_o         one-cycle result / write-enable pulse
//   busy_o          engine occupied (BUSY or DONE)
//   stall_o         combinational hold request to PC, IF/ID and ID/EXE
module exe_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dataA_i,
  input  logic [XLEN-1:0] dataB_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            stall_o
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_bzero;
  logic [XLEN:0]     r_hi;   // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;   // multiplier shifting out / dividend -> quotient
  logic [XLEN-1:0]   r_b;    // multiplicand / divisor magnitude

  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN+1:0]   w_shift;
  logic [XLEN+1:0]   w_diff;
  logic              w_ge;
  logic [XLEN:0]     w_hi_n;
  logic [XLEN-1:0]   w_lo_n;
  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res;

  // Operand sign handling at issue: MULH/DIV/REM signed on both, MULHSU on A only
  always_comb begin
    w_sgn_a = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    w_sgn_b = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    w_neg_a = w_sgn_a & dataA_i[XLEN-1];
    w_neg_b = w_sgn_b & dataB_i[XLEN-1];
    w_mag_a = w_neg_a ? (XLEN'(0) - dataA_i) : dataA_i;
    w_mag_b = w_neg_b ? (XLEN'(0) - dataB_i) : dataB_i;
  end

  // One iteration: radix-2 shift-add for multiply, restoring step for divide
  always_comb begin
    w_sum   = {1'b0, r_hi[XLEN-1:0]} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {2'b00, r_b};
    w_ge    = ~w_diff[XLEN+1];
    if (r_op[2]) begin
      w_hi_n = w_ge ? w_diff[XLEN:0] : w_shift[XLEN:0];
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_n = {1'b0, w_sum[XLEN:1]};
      w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign correction and result select on the post-final-iteration values.
  // Signed overflow needs no special path: |A|/1 = 0x80..0 negates to itself.
  always_comb begin
    w_prod   = {w_hi_n[XLEN-1:0], w_lo_n};
    w_prod_s = (r_neg_a ^ r_neg_b) ? (PW'(0) - w_prod) : w_prod;
    w_quo    = r_bzero ? '1 : ((r_neg_a ^ r_neg_b) ? (XLEN'(0) - w_lo_n) : w_lo_n);
    w_rem    = r_neg_a ? (XLEN'(0) - w_hi_n[XLEN-1:0]) : w_hi_n[XLEN-1:0];
    case (r_op)
      3'b000:                w_res = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod_s[PW-1:XLEN];
      3'b100, 3'b101:        w_res = w_quo;
      default:               w_res = w_rem;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start_i && !flush_i) begin
            r_state <= S_BUSY;
            r_op    <= op_i;
            r_rd    <= rd_i;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_bzero <= (dataB_i == '0);
            r_hi    <= '0;
            r_lo    <= w_mag_a;
            r_b     <= w_mag_b;
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_state  <= S_DONE;
              result_o <= w_res;
              rd_o     <= r_rd;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush landing in DONE must still kill the write strobe
  assign valid_o = (r_state == S_DONE) && !flush_i;
  assign busy_o  = (r_state != S_IDLE);
  assign stall_o = ((r_state == S_IDLE) && start_i && !flush_i) || (r_state == S_BUSY);

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: latency, results, special cases,
// flush and reset behaviour.
module tb_exe_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dataA_i;
  logic [31:0] dataB_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        valid_o;
  logic        busy_o;
  logic        stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  exe_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .dataA_i  (dataA_i),
    .dataB_i  (dataB_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .result_o (result_o),
    .rd_o     (rd_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle (cycle 0) and check the full timeline
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    op_i    = op;
    dataA_i = a;
    dataB_i = b;
    rd_i    = rd;
    start_i = 1'b1;
    @(negedge clk);
    chk({tag, "_stall_c0"}, {31'd0, stall_o}, 32'd1);
    for (int c = 1; c <= 32; c++) begin
      step();
      start_i = 1'b0;
      dataA_i = 32'hDEAD_BEEF;
      dataB_i = 32'h0BAD_F00D;
      @(negedge clk);
      chk({tag, "_busy_ctl"}, {29'd0, stall_o, valid_o, busy_o}, 32'h5);
    end
    step();
    @(negedge clk);
    chk({tag, "_done_ctl"}, {29'd0, stall_o, valid_o, busy_o}, 32'h3);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
    step();
    @(negedge clk);
    chk({tag, "_idle_ctl"}, {29'd0, stall_o, valid_o, busy_o}, 32'h0);
  endtask

  logic seen_valid;

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    dataA_i = '0;
    dataB_i = '0;
    rd_i    = '0;
    step();
    step();
    @(negedge clk);
    chk("reset_result", result_o, 32'h0);
    chk("reset_rd", {27'd0, rd_o}, 32'h0);
    chk("reset_ctl", {29'd0, stall_o, valid_o, busy_o}, 32'h0);

    // Reset wins over a simultaneous start
    step();
    start_i = 1'b1;
    op_i    = OP_MUL;
    step();
    chk("rst_over_start_busy", {31'd0, busy_o}, 32'd0);
    rst     = 1'b0;
    start_i = 1'b0;

    step(); do_op("mul_7_m3",       OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd7,  32'hFFFF_FFEB);
    step(); do_op("mulhu_ones",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE);
    step(); do_op("mulh_min",       OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000);
    step(); do_op("mulhsu_m1_2",    OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF);
    step(); do_op("mul_hex",        OP_MUL,    32'h1234_5678, 32'h0000_0010, 5'd4,  32'h2345_6780);
    step(); do_op("mulhu_hex",      OP_MULHU,  32'h1234_5678, 32'h0000_0010, 5'd5,  32'h0000_0001);
    step(); do_op("div_m7_2",       OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFD);
    step(); do_op("rem_m7_2",       OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF);
    step(); do_op("divu_big_2",     OP_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'h7FFF_FFFC);
    step(); do_op("divu_100_7",     OP_DIVU,   32'h0000_0064, 32'h0000_0007, 5'd10, 32'h0000_000E);
    step(); do_op("remu_100_7",     OP_REMU,   32'h0000_0064, 32'h0000_0007, 5'd11, 32'h0000_0002);
    step(); do_op("div_5_0",        OP_DIV,    32'h0000_0005, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF);
    step(); do_op("div_m5_0",       OP_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 5'd13, 32'hFFFF_FFFF);
    step(); do_op("remu_5_0",       OP_REMU,   32'h0000_0005, 32'h0000_0000, 5'd14, 32'h0000_0005);
    step(); do_op("rem_m5_0",       OP_REM,    32'hFFFF_FFFB, 32'h0000_0000, 5'd15, 32'hFFFF_FFFB);
    step(); do_op("div_ovf",        OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
    step(); do_op("rem_ovf",        OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000);

    // Flush in cycle 10 of a DIV, then a MUL issued in cycle 11
    step();
    op_i = OP_DIV; dataA_i = 32'd100; dataB_i = 32'd7; rd_i = 5'd3; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 2; c <= 10; c++) step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", {31'd0, stall_o}, 32'd1);
    step();
    flush_i = 1'b0;
    chk("flush_busy_idle", {30'd0, valid_o, busy_o}, 32'd0);
    do_op("mul_after_flush", OP_MUL, 32'd3, 32'd5, 5'd9, 32'd15);

    // Flush arriving in DONE kills the write strobe
    step();
    op_i = OP_DIVU; dataA_i = 32'd100; dataB_i = 32'd7; rd_i = 5'd4; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 2; c <= 33; c++) step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_done_valid", {30'd0, valid_o, busy_o}, 32'h1);
    step();
    flush_i = 1'b0;
    chk("flush_done_idle", {30'd0, valid_o, busy_o}, 32'h0);

    // Reset in cycle 20 of a MUL
    step();
    op_i = OP_MUL; dataA_i = 32'd7; dataB_i = 32'hFFFF_FFFD; rd_i = 5'd5; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 2; c <= 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy_result", result_o, 32'h0);
    chk("rst_busy_rd", {27'd0, rd_o}, 32'h0);
    chk("rst_busy_ctl", {29'd0, stall_o, valid_o, busy_o}, 32'h0);
    seen_valid = 1'b0;
    for (int c = 22; c <= 40; c++) begin
      step();
      @(negedge clk);
      if (valid_o) seen_valid = 1'b1;
    end
    chk("rst_busy_no_valid", {31'd0, seen_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
